// File: rtl/easyaxi_rd_mux.sv
// rtl/easyaxi_rd_mux.sv - N-to-1 AXI read-channel interconnect with round-robin AR arbitration and ID-based R routing
module easyaxi_rd_mux #(
    parameter int MST_NUM   = 4,
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int LEN_W     = 8,
    parameter int OST_DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [MST_NUM-1:0]                  mst_arvalid,
    output logic [MST_NUM-1:0]                  mst_arready,
    input  logic [MST_NUM*ID_W-1:0]             mst_arid,
    input  logic [MST_NUM*ADDR_W-1:0]           mst_araddr,
    input  logic [MST_NUM*LEN_W-1:0]            mst_arlen,
    input  logic [MST_NUM*3-1:0]                mst_arsize,
    input  logic [MST_NUM*2-1:0]                mst_arburst,
    output logic                                slv_arvalid,
    input  logic                                slv_arready,
    output logic [$clog2(MST_NUM)+ID_W-1:0]     slv_arid,
    output logic [ADDR_W-1:0]                   slv_araddr,
    output logic [LEN_W-1:0]                    slv_arlen,
    output logic [2:0]                          slv_arsize,
    output logic [1:0]                          slv_arburst,
    input  logic                                slv_rvalid,
    input  logic                                slv_rlast,
    output logic                                slv_rready,
    input  logic [$clog2(MST_NUM)+ID_W-1:0]     slv_rid,
    input  logic [DATA_W-1:0]                   slv_rdata,
    input  logic [1:0]                          slv_rresp,
    output logic [MST_NUM-1:0]                  mst_rvalid,
    output logic [MST_NUM-1:0]                  mst_rlast,
    input  logic [MST_NUM-1:0]                  mst_rready,
    output logic [ID_W-1:0]                     mst_rid,
    output logic [DATA_W-1:0]                   mst_rdata,
    output logic [1:0]                          mst_rresp,
    output logic                                rd_idle,
    output logic                                err
);

    localparam int IDX_W = $clog2(MST_NUM);
    localparam int SID_W = IDX_W + ID_W;
    localparam int CNT_W = $clog2(OST_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OST_DEPTH);

    logic                 slv_arvalid_q;
    logic [SID_W-1:0]     slv_arid_q;
    logic [ADDR_W-1:0]    slv_araddr_q;
    logic [LEN_W-1:0]     slv_arlen_q;
    logic [2:0]           slv_arsize_q;
    logic [1:0]           slv_arburst_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [CNT_W-1:0]     ost_cnt_q [MST_NUM];
    logic                 err_q;

    logic [MST_NUM-1:0]   eligible;
    logic [MST_NUM-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_any;
    logic                 slot_free;
    logic                 ar_hs;
    logic [IDX_W-1:0]     r_idx;
    logic [MST_NUM-1:0]   r_sel;
    logic                 r_routable;
    logic                 r_last_hs;
    logic [MST_NUM-1:0]   cnt_inc;
    logic [MST_NUM-1:0]   cnt_dec;

    always_comb begin
        for (int i = 0; i < MST_NUM; i++) begin
            eligible[i] = mst_arvalid[i] && (ost_cnt_q[i] < CNT_MAX);
        end
    end

    // Search starts at rr_ptr_q and wraps; the first eligible master wins.
    always_comb begin : rr_arb
        int j;
        j         = 0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < MST_NUM; k++) begin
            j = (int'(rr_ptr_q) + k) % MST_NUM;
            if (!grant_any && eligible[j[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = j[IDX_W-1:0];
            end
        end
        grant = MST_NUM'(grant_any) << grant_idx;
    end

    assign slot_free   = !slv_arvalid_q || slv_arready;
    assign ar_hs       = grant_any && slot_free && !rst;
    assign mst_arready = grant & {MST_NUM{slot_free && !rst}};

    assign r_idx = slv_rid[SID_W-1:ID_W];

    always_comb begin
        for (int i = 0; i < MST_NUM; i++) begin
            r_sel[i] = (r_idx == IDX_W'(i));
        end
    end

    // An index with no master behind it is drained so the slave never stalls on it.
    assign r_routable = |r_sel;
    assign slv_rready = r_routable ? |(r_sel & mst_rready) : 1'b1;
    assign mst_rvalid = slv_rvalid ? r_sel : '0;
    assign mst_rlast  = slv_rlast ? r_sel : '0;
    assign mst_rid    = slv_rid[ID_W-1:0];
    assign mst_rdata  = slv_rdata;
    assign mst_rresp  = slv_rresp;
    assign r_last_hs  = slv_rvalid && slv_rready && slv_rlast;

    assign cnt_inc = ar_hs ? grant : '0;
    assign cnt_dec = r_last_hs ? r_sel : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            slv_arvalid_q <= 1'b0;
            slv_arid_q    <= '0;
            slv_araddr_q  <= '0;
            slv_arlen_q   <= '0;
            slv_arsize_q  <= '0;
            slv_arburst_q <= '0;
            rr_ptr_q      <= '0;
            err_q         <= 1'b0;
            for (int i = 0; i < MST_NUM; i++) begin
                ost_cnt_q[i] <= '0;
            end
        end else begin
            if (ar_hs) begin
                slv_arvalid_q <= 1'b1;
                slv_arid_q    <= {grant_idx, mst_arid[grant_idx*ID_W +: ID_W]};
                slv_araddr_q  <= mst_araddr[grant_idx*ADDR_W +: ADDR_W];
                slv_arlen_q   <= mst_arlen[grant_idx*LEN_W +: LEN_W];
                slv_arsize_q  <= mst_arsize[grant_idx*3 +: 3];
                slv_arburst_q <= mst_arburst[grant_idx*2 +: 2];
                rr_ptr_q      <= (int'(grant_idx) == MST_NUM - 1) ? '0 : grant_idx + 1'b1;
            end else if (slv_arready) begin
                slv_arvalid_q <= 1'b0;
            end

            for (int i = 0; i < MST_NUM; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    ost_cnt_q[i] <= ost_cnt_q[i] + 1'b1;
                end else if (cnt_dec[i] && !cnt_inc[i]) begin
                    if (ost_cnt_q[i] == '0) begin
                        err_q <= 1'b1;
                    end else begin
                        ost_cnt_q[i] <= ost_cnt_q[i] - 1'b1;
                    end
                end
            end

            if (slv_rvalid && !r_routable) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_idle = !slv_arvalid_q;
        for (int i = 0; i < MST_NUM; i++) begin
            if (ost_cnt_q[i] != '0) begin
                rd_idle = 1'b0;
            end
        end
    end

    assign slv_arvalid = slv_arvalid_q;
    assign slv_arid    = slv_arid_q;
    assign slv_araddr  = slv_araddr_q;
    assign slv_arlen   = slv_arlen_q;
    assign slv_arsize  = slv_arsize_q;
    assign slv_arburst = slv_arburst_q;
    assign err         = err_q;

endmodule

// File: tb/tb_easyaxi_rd_mux.sv
// tb/tb_easyaxi_rd_mux.sv - scoreboard bench for easyaxi_rd_mux (3 masters, 2 outstanding per master)
module tb_easyaxi_rd_mux;

    localparam int M  = 3;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LW = 8;
    localparam int OD = 2;
    localparam int SW = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [M-1:0]    mst_arvalid, mst_arready;
    logic [M*IW-1:0] mst_arid;
    logic [M*AW-1:0] mst_araddr;
    logic [M*LW-1:0] mst_arlen;
    logic [M*3-1:0]  mst_arsize;
    logic [M*2-1:0]  mst_arburst;
    logic            slv_arvalid, slv_arready;
    logic [SW-1:0]   slv_arid;
    logic [AW-1:0]   slv_araddr;
    logic [LW-1:0]   slv_arlen;
    logic [2:0]      slv_arsize;
    logic [1:0]      slv_arburst;
    logic            slv_rvalid, slv_rlast, slv_rready;
    logic [SW-1:0]   slv_rid;
    logic [DW-1:0]   slv_rdata;
    logic [1:0]      slv_rresp;
    logic [M-1:0]    mst_rvalid, mst_rlast, mst_rready;
    logic [IW-1:0]   mst_rid;
    logic [DW-1:0]   mst_rdata;
    logic [1:0]      mst_rresp;
    logic            rd_idle, err;

    int checks   = 0;
    int failures = 0;
    logic [50:0] exp_ar[$];
    logic [76:0] exp_r[$];
    int          rr_idx [4] = '{0, 1, 2, 0};
    logic [2:0]  rr_gnt [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    always #5 clk = ~clk;

    easyaxi_rd_mux #(.MST_NUM(M), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .OST_DEPTH(OD)) dut (
        .clk(clk), .rst(rst),
        .mst_arvalid(mst_arvalid), .mst_arready(mst_arready), .mst_arid(mst_arid),
        .mst_araddr(mst_araddr), .mst_arlen(mst_arlen), .mst_arsize(mst_arsize), .mst_arburst(mst_arburst),
        .slv_arvalid(slv_arvalid), .slv_arready(slv_arready), .slv_arid(slv_arid),
        .slv_araddr(slv_araddr), .slv_arlen(slv_arlen), .slv_arsize(slv_arsize), .slv_arburst(slv_arburst),
        .slv_rvalid(slv_rvalid), .slv_rlast(slv_rlast), .slv_rready(slv_rready), .slv_rid(slv_rid),
        .slv_rdata(slv_rdata), .slv_rresp(slv_rresp),
        .mst_rvalid(mst_rvalid), .mst_rlast(mst_rlast), .mst_rready(mst_rready), .mst_rid(mst_rid),
        .mst_rdata(mst_rdata), .mst_rresp(mst_rresp),
        .rd_idle(rd_idle), .err(err)
    );

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(int m, logic v, logic [3:0] id, logic [31:0] a, logic [7:0] l);
        mst_arvalid[m]          = v;
        mst_arid[m*IW +: IW]    = id;
        mst_araddr[m*AW +: AW]  = a;
        mst_arlen[m*LW +: LW]   = l;
    endtask

    function automatic void push_ar(int m, logic [3:0] id, logic [31:0] a, logic [7:0] l);
        exp_ar.push_back({2'(m), id, a, l, 3'd3, 2'd1});
    endfunction

    task automatic set_r(logic v, logic [1:0] idx, logic [3:0] id, logic [63:0] d, logic last);
        slv_rvalid = v;
        slv_rid    = {idx, id};
        slv_rdata  = d;
        slv_rresp  = d[1:0];
        slv_rlast  = last;
    endtask

    // One R beat cycle: drive, record the expected master-side view, stop at the falling edge.
    task automatic beat(logic [1:0] idx, logic [3:0] id, logic [63:0] d, logic last,
                        logic [2:0] rdy, logic [2:0] mv, logic [2:0] ml, logic srr);
        tick();
        set_r(1'b1, idx, id, d, last);
        mst_rready = rdy;
        exp_r.push_back({mv, ml, id, d, d[1:0], srr});
        @(negedge clk);
    endtask

    task automatic r_idle();
        tick();
        set_r(1'b0, 2'd0, 4'h0, 64'h0, 1'b0);
        mst_rready = '1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (slv_arvalid && slv_arready) begin
                if (exp_ar.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ar_extra actual=%0h required=none", slv_arid);
                end else begin
                    chk("ar_payload", {slv_arid, slv_araddr, slv_arlen, slv_arsize, slv_arburst}, exp_ar.pop_front());
                end
            end
            if (slv_rvalid) begin
                if (exp_r.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL r_extra actual=%0h required=none", slv_rid);
                end else begin
                    chk("r_route", {mst_rvalid, mst_rlast, mst_rid, mst_rdata, mst_rresp, slv_rready}, exp_r.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mst_arvalid = '0; mst_arid = '0; mst_araddr = '0; mst_arlen = '0;
        mst_arsize = {M{3'd3}}; mst_arburst = {M{2'd1}};
        slv_arready = 1'b0; mst_rready = '1;
        set_r(1'b0, 2'd0, 4'h0, 64'h0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        set_ar(0, 1'b1, 4'h1, 32'h40, 8'd0);
        @(negedge clk);
        chk("rst_arready", mst_arready, 3'b000);
        chk("rst_slv_arvalid", slv_arvalid, 1'b0);
        chk("rst_payload", {slv_arid, slv_araddr, slv_arlen}, 0);
        chk("rst_idle", rd_idle, 1'b1);
        chk("rst_err", err, 1'b0);
        tick();
        set_ar(0, 1'b0, 4'h1, 32'h40, 8'd0);
        rst = 1'b0;
        slv_arready = 1'b1;

        // single master, 4-beat burst
        set_ar(0, 1'b1, 4'h3, 32'h100, 8'd3);
        push_ar(0, 4'h3, 32'h100, 8'd3);
        @(negedge clk);
        chk("t1_arready", mst_arready, 3'b001);
        tick();
        set_ar(0, 1'b0, 4'h3, 32'h100, 8'd3);
        @(negedge clk);
        chk("t1_latency", slv_arvalid, 1'b1);
        chk("t1_slv_arid", slv_arid, 6'h03);
        tick();
        @(negedge clk);
        chk("t1_slot_clear", slv_arvalid, 1'b0);
        for (int b = 0; b < 4; b++) begin
            beat(2'd0, 4'h3, 64'hA000 + 64'(b), b == 3, 3'b111, 3'b001, (b == 3) ? 3'b001 : 3'b000, 1'b1);
            if (b == 0) chk("t1_busy", rd_idle, 1'b0);
        end
        r_idle();
        chk("t1_idle", rd_idle, 1'b1);

        // round robin from a fresh pointer
        tick();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        for (int m = 0; m < M; m++) set_ar(m, 1'b1, 4'(8 + m), 32'h1000 * (m + 1), 8'(m));
        for (int c = 0; c < 4; c++) begin
            push_ar(rr_idx[c], 4'(8 + rr_idx[c]), 32'h1000 * (rr_idx[c] + 1), 8'(rr_idx[c]));
            @(negedge clk);
            chk("rr_grant", mst_arready, rr_gnt[c]);
            tick();
        end
        mst_arvalid = '0;

        // outstanding limit on master 0 (two in flight)
        set_ar(0, 1'b1, 4'hC, 32'h2000, 8'd1);
        @(negedge clk);
        chk("lim_block0", mst_arready, 3'b000);
        tick();
        @(negedge clk);
        chk("lim_block1", mst_arready, 3'b000);
        beat(2'd0, 4'h8, 64'hB0, 1'b1, 3'b111, 3'b001, 3'b001, 1'b1);
        chk("lim_same_cycle", mst_arready, 3'b000);
        tick();
        set_r(1'b0, 2'd0, 4'h0, 64'h0, 1'b0);
        push_ar(0, 4'hC, 32'h2000, 8'd1);
        @(negedge clk);
        chk("lim_reenable", mst_arready, 3'b001);
        tick();
        mst_arvalid[0] = 1'b0;

        // AR handshake and rlast for master 0 in the same cycle at count 1
        @(negedge clk);
        beat(2'd0, 4'hC, 64'hC0, 1'b1, 3'b111, 3'b001, 3'b001, 1'b1);
        tick();
        set_r(1'b1, 2'd0, 4'hC, 64'hC1, 1'b1);
        exp_r.push_back({3'b001, 3'b001, 4'hC, 64'hC1, 2'b01, 1'b1});
        set_ar(0, 1'b1, 4'hD, 32'h3000, 8'd2);
        push_ar(0, 4'hD, 32'h3000, 8'd2);
        @(negedge clk);
        chk("sim_arready", mst_arready, 3'b001);
        tick();
        set_r(1'b0, 2'd0, 4'h0, 64'h0, 1'b0);
        set_ar(0, 1'b1, 4'hE, 32'h3100, 8'd2);
        push_ar(0, 4'hE, 32'h3100, 8'd2);
        @(negedge clk);
        chk("sim_cnt_one", mst_arready, 3'b001);
        tick();
        @(negedge clk);
        chk("sim_cnt_full", mst_arready, 3'b000);
        tick();
        mst_arvalid[0] = 1'b0;

        // drain: m0 x2, m1 (with one stalled beat), m2
        @(negedge clk);
        beat(2'd0, 4'hD, 64'hD0, 1'b0, 3'b111, 3'b001, 3'b000, 1'b1);
        beat(2'd0, 4'hD, 64'hD1, 1'b1, 3'b111, 3'b001, 3'b001, 1'b1);
        beat(2'd0, 4'hE, 64'hE0, 1'b1, 3'b111, 3'b001, 3'b001, 1'b1);
        beat(2'd1, 4'h9, 64'h90, 1'b1, 3'b101, 3'b010, 3'b010, 1'b0);
        beat(2'd1, 4'h9, 64'h90, 1'b1, 3'b111, 3'b010, 3'b010, 1'b1);
        beat(2'd2, 4'hA, 64'hA0, 1'b1, 3'b111, 3'b100, 3'b100, 1'b1);
        r_idle();
        chk("drain_idle", rd_idle, 1'b1);
        chk("drain_err", err, 1'b0);

        // slave back-pressure with master 2 requesting
        tick();
        slv_arready = 1'b0;
        set_ar(2, 1'b1, 4'h5, 32'h4000, 8'd7);
        push_ar(2, 4'h5, 32'h4000, 8'd7);
        @(negedge clk);
        chk("bp_first", mst_arready, 3'b100);
        tick();
        set_ar(2, 1'b1, 4'h6, 32'h4400, 8'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_arready", mst_arready, 3'b000);
            chk("bp_hold", {slv_arvalid, slv_araddr, slv_arid, slv_arlen}, {1'b1, 32'h4000, 6'h25, 8'd7});
            tick();
        end
        slv_arready = 1'b1;
        push_ar(2, 4'h6, 32'h4400, 8'd1);
        @(negedge clk);
        chk("bp_release", mst_arready, 3'b100);
        tick();
        mst_arvalid[2] = 1'b0;
        @(negedge clk);
        beat(2'd2, 4'h5, 64'h50, 1'b1, 3'b111, 3'b100, 3'b100, 1'b1);
        beat(2'd2, 4'h6, 64'h60, 1'b1, 3'b111, 3'b100, 3'b100, 1'b1);
        r_idle();
        chk("bp_idle", rd_idle, 1'b1);

        // unroutable index 3
        beat(2'd3, 4'h5, 64'hDEAD, 1'b1, 3'b000, 3'b000, 3'b000, 1'b1);
        chk("unr_rready", slv_rready, 1'b1);
        chk("unr_rvalid", mst_rvalid, 3'b000);
        r_idle();
        chk("unr_err", err, 1'b1);
        tick();
        @(negedge clk);
        chk("unr_err_sticky", err, 1'b1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("err_clear", err, 1'b0);

        // rlast for a master with nothing outstanding
        beat(2'd1, 4'h2, 64'h77, 1'b1, 3'b111, 3'b010, 3'b010, 1'b1);
        r_idle();
        chk("zero_dec_err", err, 1'b1);
        chk("zero_dec_idle", rd_idle, 1'b1);

        chk("ar_queue_empty", exp_ar.size(), 0);
        chk("r_queue_empty", exp_r.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
